// File: rtl/sd_seq_pkg.sv
// Shared types and helpers for the SD block read sequencer.
package sd_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_ADVANCE   = 2'd3
  } seq_state_e;

  // Width needed to hold a byte count from 0 up to and including block_bytes.
  function automatic int unsigned cnt_width(input int unsigned block_bytes);
    return $clog2(block_bytes + 1);
  endfunction

endpackage

// File: rtl/sd_byte_fifo.sv
// Small synchronous byte FIFO; a push into a full FIFO succeeds only with a same-cycle pop.
module sd_byte_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop_ready,
  output logic [WIDTH-1:0] rd_data_c,
  output logic             empty,
  output logic             push_ok_c
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_next_c;
  logic             full;
  logic             pop_c;

  assign pop_c     = pop_ready && !empty;
  assign push_ok_c = push && (!full || pop_c);
  // Head is forced to zero while empty so the output reads 0 out of reset.
  assign rd_data_c = empty ? '0 : mem[rd_ptr];

  // Occupancy after this cycle's accepted push and pop.
  always_comb begin
    count_next_c = count;
    if (push_ok_c && !pop_c) begin
      count_next_c = count + CW'(1);
    end else if (!push_ok_c && pop_c) begin
      count_next_c = count - CW'(1);
    end
  end

  // Pointers, occupancy and registered full/empty flags.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
    end else begin
      count <= count_next_c;
      empty <= (count_next_c == '0);
      full  <= (count_next_c == CW'(DEPTH));
      if (push_ok_c) wr_ptr <= wr_ptr + AW'(1);
      if (pop_c)     rd_ptr <= rd_ptr + AW'(1);
    end
  end

  // Storage; contents need no reset since empty gates the output.
  always_ff @(posedge clock) begin
    if (push_ok_c) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/sd_block_sequencer.sv
// Walks the card address space issuing block reads, counts/checksums bytes, queues them downstream.
module sd_block_sequencer
  import sd_seq_pkg::*;
#(
  parameter int unsigned       ADDR_W      = 32,
  parameter int unsigned       STRIDE      = 256,
  parameter logic [ADDR_W-1:0] ADDR_LAST   = ADDR_W'(32'h00FF_FF00),
  parameter int unsigned       BLOCK_BYTES = 512,
  parameter int unsigned       FIFO_DEPTH  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              loop_mode,
  input  logic              halt,
  output logic [ADDR_W-1:0] sd_addr,
  output logic              sd_begin_read,
  input  logic              sd_idle,
  input  logic              sd_valid_read,
  input  logic [7:0]        sd_byte,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              overflow,
  output logic              short_block,
  output logic [15:0]       blocks_done,
  output logic [15:0]       checksum
);

  localparam int unsigned CNT_W = cnt_width(BLOCK_BYTES);

  seq_state_e       state;
  logic [CNT_W-1:0] byte_cnt;
  logic [15:0]      run_sum;
  logic [CNT_W-1:0] cnt_upd_c;
  logic [15:0]      sum_upd_c;
  logic             push_c;
  logic             fifo_empty;
  logic             fifo_push_ok_c;

  assign push_c    = (state == ST_WAIT_DONE) && sd_valid_read;
  assign out_valid = ~fifo_empty;

  // Byte counter (saturating) and running sum including this cycle's strobe.
  always_comb begin
    cnt_upd_c = byte_cnt;
    sum_upd_c = run_sum;
    if (push_c) begin
      if (byte_cnt != CNT_W'(BLOCK_BYTES)) cnt_upd_c = byte_cnt + CNT_W'(1);
      sum_upd_c = run_sum + 16'(sd_byte);
    end
  end

  // Sequencer FSM with address, counters, checksum and sticky error flags.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      sd_addr       <= '0;
      sd_begin_read <= 1'b0;
      busy          <= 1'b0;
      overflow      <= 1'b0;
      short_block   <= 1'b0;
      blocks_done   <= '0;
      checksum      <= '0;
      byte_cnt      <= '0;
      run_sum       <= '0;
    end else begin
      byte_cnt <= cnt_upd_c;
      run_sum  <= sum_upd_c;
      if (push_c && !fifo_push_ok_c) overflow <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (start) begin
            sd_addr       <= '0;
            byte_cnt      <= '0;
            run_sum       <= '0;
            overflow      <= 1'b0;
            short_block   <= 1'b0;
            sd_begin_read <= 1'b1;
            busy          <= 1'b1;
            state         <= ST_ISSUE;
          end
        end

        ST_ISSUE: begin
          if (!sd_idle) begin
            sd_begin_read <= 1'b0;
            state         <= ST_WAIT_DONE;
          end
        end

        ST_WAIT_DONE: begin
          if (sd_idle) begin
            if (cnt_upd_c == CNT_W'(BLOCK_BYTES)) begin
              checksum    <= sum_upd_c;
              blocks_done <= blocks_done + 16'd1;
              state       <= ST_ADVANCE;
            end else begin
              short_block <= 1'b1;
              busy        <= 1'b0;
              state       <= ST_IDLE;
            end
          end
        end

        ST_ADVANCE: begin
          byte_cnt <= '0;
          run_sum  <= '0;
          if (halt) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else if (sd_addr >= ADDR_LAST) begin
            sd_addr <= '0;
            if (loop_mode) begin
              sd_begin_read <= 1'b1;
              state         <= ST_ISSUE;
            end else begin
              busy  <= 1'b0;
              state <= ST_IDLE;
            end
          end else begin
            sd_addr       <= sd_addr + ADDR_W'(STRIDE);
            sd_begin_read <= 1'b1;
            state         <= ST_ISSUE;
          end
        end

        default: begin
          busy          <= 1'b0;
          sd_begin_read <= 1'b0;
          state         <= ST_IDLE;
        end
      endcase
    end
  end

  // Output byte queue toward the downstream consumer.
  sd_byte_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(8)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push_c),
    .push_data (sd_byte),
    .pop_ready (out_ready),
    .rd_data_c (out_data),
    .empty     (fifo_empty),
    .push_ok_c (fifo_push_ok_c)
  );

endmodule

// File: tb/tb_sd_block_sequencer.sv
// Directed bench for sd_block_sequencer with a small SDIF responder driven from tasks.
module tb_sd_block_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        loop_mode;
  logic        halt;
  logic [31:0] sd_addr;
  logic        sd_begin_read;
  logic        sd_idle;
  logic        sd_valid_read;
  logic [7:0]  sd_byte;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        overflow;
  logic        short_block;
  logic [15:0] blocks_done;
  logic [15:0] checksum;

  int errors = 0;
  int checks = 0;
  logic [7:0] got_q[$];

  sd_block_sequencer #(
    .ADDR_W(32), .STRIDE(256), .ADDR_LAST(32'h200), .BLOCK_BYTES(4), .FIFO_DEPTH(16)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .loop_mode(loop_mode), .halt(halt),
    .sd_addr(sd_addr), .sd_begin_read(sd_begin_read), .sd_idle(sd_idle),
    .sd_valid_read(sd_valid_read), .sd_byte(sd_byte),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .overflow(overflow), .short_block(short_block),
    .blocks_done(blocks_done), .checksum(checksum)
  );

  always #5 clock = ~clock;

  // Record every byte the consumer accepts (sampled after the negedge drives settle).
  always begin
    @(negedge clock);
    #2;
    if (!reset && out_valid && out_ready) got_q.push_back(out_data);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic reset_dut();
    reset = 1'b1; start = 1'b0; halt = 1'b0; sd_idle = 1'b1; sd_valid_read = 1'b0; sd_byte = 8'h00;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    got_q.delete();
    @(negedge clock);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_begin(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (sd_begin_read) begin
        ok = 1'b1;
        break;
      end
      @(negedge clock);
    end
  endtask

  // SDIF responder: accept begin_read, stream n bytes, then return to idle.
  task automatic run_block(input int n, input logic [7:0] first, input logic [7:0] step,
                           input logic ready_on_strobe, output logic [31:0] addr);
    logic ok;
    wait_begin(ok);
    check("begin_read_seen", 32'(ok), 32'd1);
    addr = sd_addr;
    sd_idle = 1'b0;
    @(negedge clock);
    check("begin_read_drop", 32'(sd_begin_read), 32'd0);
    for (int i = 0; i < n; i++) begin
      sd_valid_read = 1'b1;
      sd_byte = first + 8'(i) * step;
      if (ready_on_strobe) out_ready = 1'b1;
      @(negedge clock);
    end
    sd_valid_read = 1'b0;
    sd_idle = 1'b1;
    if (ready_on_strobe) out_ready = 1'b0;
    @(negedge clock);
  endtask

  typedef struct {
    logic        do_reset;
    logic        do_start;
    logic        lp;
    logic        hl;
    int          n;
    logic [7:0]  first;
    logic [7:0]  step;
    logic [31:0] exp_cap;
    logic [15:0] exp_blocks;
    logic [15:0] exp_sum;
    logic [31:0] exp_addr;
    logic        exp_busy;
  } vec_t;

  vec_t        vecs[7];
  logic [31:0] cap;
  logic [7:0]  exp_b;

  initial begin
    // one-shot run: 0x000, 0x100, 0x200 then stop
    vecs[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 4, 8'h01, 8'h00, 32'h000, 16'd1, 16'h0004, 32'h100, 1'b1};
    vecs[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 4, 8'h01, 8'h00, 32'h100, 16'd2, 16'h0004, 32'h200, 1'b1};
    vecs[2] = '{1'b0, 1'b0, 1'b0, 1'b0, 4, 8'h01, 8'h00, 32'h200, 16'd3, 16'h0004, 32'h000, 1'b0};
    // loop run with varied bytes, halted during the 4th block
    vecs[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 4, 8'h10, 8'h01, 32'h000, 16'd1, 16'h0046, 32'h100, 1'b1};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 4, 8'hFF, 8'h00, 32'h100, 16'd2, 16'h03FC, 32'h200, 1'b1};
    vecs[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 4, 8'h80, 8'h10, 32'h200, 16'd3, 16'h0260, 32'h000, 1'b1};
    vecs[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 4, 8'h01, 8'h00, 32'h000, 16'd4, 16'h0004, 32'h000, 1'b0};

    reset = 1'b1; start = 1'b0; loop_mode = 1'b0; halt = 1'b0; sd_idle = 1'b1;
    sd_valid_read = 1'b0; sd_byte = 8'h00; out_ready = 1'b1;
    #1;
    check("rst_sd_addr", sd_addr, 32'h0);
    check("rst_begin_read", 32'(sd_begin_read), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_short_block", 32'(short_block), 32'd0);
    check("rst_blocks_done", 32'(blocks_done), 32'd0);
    check("rst_checksum", 32'(checksum), 32'd0);
    reset_dut();

    for (int i = 0; i < 7; i++) begin
      if (vecs[i].do_reset) reset_dut();
      loop_mode = vecs[i].lp;
      halt = vecs[i].hl;
      if (vecs[i].do_start) pulse_start();
      run_block(vecs[i].n, vecs[i].first, vecs[i].step, 1'b0, cap);
      check($sformatf("v%0d_addr_read", i), cap, vecs[i].exp_cap);
      check($sformatf("v%0d_blocks_done", i), 32'(blocks_done), 32'(vecs[i].exp_blocks));
      check($sformatf("v%0d_checksum", i), 32'(checksum), 32'(vecs[i].exp_sum));
      @(negedge clock);
      check($sformatf("v%0d_sd_addr_next", i), sd_addr, vecs[i].exp_addr);
      check($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].exp_busy));
      if (i == 2) begin
        repeat (3) @(negedge clock);
        check("oneshot_bytes_out", 32'(got_q.size()), 32'd12);
        for (int k = 0; k < got_q.size(); k++) check("oneshot_byte_val", 32'(got_q[k]), 32'h01);
      end
    end
    halt = 1'b0;
    loop_mode = 1'b0;

    // short block: SDIF idles after 2 of 4 bytes
    reset_dut();
    pulse_start();
    run_block(2, 8'h05, 8'h00, 1'b0, cap);
    check("short_flag", 32'(short_block), 32'd1);
    check("short_busy", 32'(busy), 32'd0);
    check("short_blocks_done", 32'(blocks_done), 32'd0);
    check("short_checksum", 32'(checksum), 32'd0);
    repeat (3) @(negedge clock);
    check("short_bytes_out", 32'(got_q.size()), 32'd2);

    // overflow: 20-byte block into a stalled 16-deep FIFO
    reset_dut();
    out_ready = 1'b0;
    halt = 1'b1;
    pulse_start();
    run_block(20, 8'h01, 8'h01, 1'b0, cap);
    check("ovf_blocks_done", 32'(blocks_done), 32'd1);
    check("ovf_checksum", 32'(checksum), 32'd210);
    check("ovf_flag", 32'(overflow), 32'd1);
    @(negedge clock);
    check("ovf_busy", 32'(busy), 32'd0);
    check("ovf_out_valid", 32'(out_valid), 32'd1);
    check("ovf_head", 32'(out_data), 32'h01);
    check("ovf_nothing_out", 32'(got_q.size()), 32'd0);

    // full FIFO with push and pop together: nothing dropped
    pulse_start();
    check("start_clears_ovf", 32'(overflow), 32'd0);
    run_block(4, 8'hA1, 8'h01, 1'b1, cap);
    check("pp_overflow", 32'(overflow), 32'd0);
    check("pp_blocks_done", 32'(blocks_done), 32'd2);
    check("pp_checksum", 32'(checksum), 32'h028A);
    @(negedge clock);
    out_ready = 1'b1;
    for (int c = 0; c < 40 && got_q.size() < 20; c++) @(negedge clock);
    repeat (2) @(negedge clock);
    check("pp_total_out", 32'(got_q.size()), 32'd20);
    for (int k = 0; k < 20 && k < got_q.size(); k++) begin
      exp_b = (k < 16) ? 8'(k + 1) : 8'(8'hA1 + 8'(k - 16));
      check($sformatf("pp_order_%0d", k), 32'(got_q[k]), 32'(exp_b));
    end
    check("pp_drained", 32'(out_valid), 32'd0);
    halt = 1'b0;

    // reset while begin_read is high
    reset_dut();
    pulse_start();
    check("issue_begin_high", 32'(sd_begin_read), 32'd1);
    reset = 1'b1;
    #1;
    check("issue_rst_begin_read", 32'(sd_begin_read), 32'd0);
    check("issue_rst_busy", 32'(busy), 32'd0);

    // reset mid-block in WAIT_DONE with bytes queued
    reset_dut();
    out_ready = 1'b0;
    pulse_start();
    sd_idle = 1'b0;
    @(negedge clock);
    sd_valid_read = 1'b1; sd_byte = 8'h33;
    @(negedge clock);
    sd_byte = 8'h34;
    @(negedge clock);
    sd_valid_read = 1'b0;
    check("mid_out_valid", 32'(out_valid), 32'd1);
    check("mid_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_out_data", 32'(out_data), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_begin_read", 32'(sd_begin_read), 32'd0);
    check("mid_rst_sd_addr", sd_addr, 32'h0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0; sd_idle = 1'b1; out_ready = 1'b1;
    got_q.delete();
    @(negedge clock);
    check("post_rst_empty", 32'(out_valid), 32'd0);
    halt = 1'b1;
    pulse_start();
    run_block(4, 8'h02, 8'h00, 1'b0, cap);
    check("post_rst_addr_read", cap, 32'h0);
    check("post_rst_blocks", 32'(blocks_done), 32'd1);
    check("post_rst_checksum", 32'(checksum), 32'd8);
    repeat (3) @(negedge clock);
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_bytes_out", 32'(got_q.size()), 32'd4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
